// File: rtl/ps_fetch_queue.sv
// ---------------------------------------------------------------------------
// ps_fetch_queue
//
// Instruction prefetch queue between program memory (PM) and the program
// sequencer. Each accepted fetch has its address latched as an in-flight tag.
// When PM returns the word one cycle later, the {tag, word} pair is written
// into a DEPTH-entry FIFO. The head entry is presented to the decode stage.
// A redirect (flush) discards every queued word and any fetch still in flight.
//
// Optional feature: define FQ_BYPASS_EN so that a word returning into an empty
// queue is presented combinationally in its return cycle. It is written into
// the FIFO only if it is not popped in that same cycle.
//
// Parameters
//   DEPTH  queue entries (power of two, >= 2)
//   AW     fetch address width
//   IW     instruction word width
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   ps_fq_req    sequencer issues a fetch this cycle
//   ps_fq_add    address of that fetch
//   pm_fq_op     PM read data, valid the cycle after an accepted request
//   pm_fq_vld    PM data valid strobe
//   ps_fq_pop    sequencer consumes the head entry
//   ps_fq_flush  redirect: drop queued and in-flight words
//   fq_ps_op     head instruction word (0 when fq_ps_vld = 0)
//   fq_ps_add    head word address (0 when fq_ps_vld = 0)
//   fq_ps_vld    head entry valid
//   fq_ps_stall  a request in this cycle will not be accepted
//   fq_ps_cnt    occupancy
// ---------------------------------------------------------------------------
module ps_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int IW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ps_fq_req,
    input  logic [AW-1:0]              ps_fq_add,
    input  logic [IW-1:0]              pm_fq_op,
    input  logic                       pm_fq_vld,
    input  logic                       ps_fq_pop,
    input  logic                       ps_fq_flush,
    output logic [IW-1:0]              fq_ps_op,
    output logic [AW-1:0]              fq_ps_add,
    output logic                       fq_ps_vld,
    output logic                       fq_ps_stall,
    output logic [$clog2(DEPTH+1)-1:0] fq_ps_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [IW-1:0] op_mem  [DEPTH];
    logic [AW-1:0] add_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          inflight_v;
    logic [AW-1:0] tag;

    logic [CW:0]   credit;
    logic          req_acc;
    logic          ret;
    logic          stored_vld;
    logic          bypass_hit;
    logic          head_vld;
    logic          pop_eff;
    logic          push;
    logic          cnt_pop;

    // Reserve a slot for the outstanding fetch so that a returning word never
    // finds the queue full. A pop in the same cycle is not credited, which
    // keeps stall independent of ps_fq_pop.
    assign credit      = {1'b0, cnt} + {{CW{1'b0}}, inflight_v};
    assign fq_ps_stall = !ps_fq_flush && (credit >= (CW+1)'(DEPTH));
    assign req_acc     = ps_fq_req && !fq_ps_stall;

    // A return is only meaningful while a fetch is outstanding, and a flush
    // discards the word that arrives in the flush cycle.
    assign ret        = pm_fq_vld && inflight_v && !ps_fq_flush;
    assign stored_vld = (cnt != '0);

`ifdef FQ_BYPASS_EN
    assign bypass_hit = ret && (cnt == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_vld = stored_vld || bypass_hit;
    assign pop_eff  = ps_fq_pop && head_vld && !ps_fq_flush;
    // A bypassed word that is consumed on arrival never enters storage.
    assign push     = ret && !(bypass_hit && pop_eff);
    assign cnt_pop  = pop_eff && stored_vld;

    // Head presentation: storage first, then the bypass path, otherwise NOP.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        fq_ps_op  = '0;
        fq_ps_add = '0;
        if (stored_vld) begin
            fq_ps_op  = op_mem[rd_ptr];
            fq_ps_add = add_mem[rd_ptr];
        end else if (bypass_hit) begin
            fq_ps_op  = pm_fq_op;
            fq_ps_add = tag;
        end
    end

    assign fq_ps_vld = head_vld;
    assign fq_ps_cnt = cnt;

    // In-flight tag. A request accepted in the flush cycle is the redirect
    // target and stays in flight; otherwise a flush or a return retires it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            inflight_v <= 1'b0;
            tag        <= '0;
        end else if (req_acc) begin
            inflight_v <= 1'b1;
            tag        <= ps_fq_add;
        end else if (ps_fq_flush || pm_fq_vld) begin
            inflight_v <= 1'b0;
        end
    end

    // Pointers and occupancy. Pointer wrap is the natural modulo-DEPTH
    // rollover of a PW-bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (ps_fq_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (cnt_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, cnt_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // has been written, and cnt = 0 masks the outputs to 0 until then.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= pm_fq_op;
            add_mem[wr_ptr] <= tag;
        end
    end

endmodule

// File: tb/tb_ps_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ps_fetch_queue
//
// Testbench for ps_fetch_queue. A small PM model answers every accepted
// fetch in the following cycle with a random word. The expected {add, op}
// pairs are kept in a scoreboard queue. A separate monitor compares the DUT
// head against the front of that queue, and pops the queue on every
// consumption. The driver predicts stall, valid and occupancy from the queue
// size and the outstanding-fetch flag.
// ---------------------------------------------------------------------------
module tb_ps_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ps_fq_req;
    logic [AW-1:0] ps_fq_add;
    logic [IW-1:0] pm_fq_op;
    logic          pm_fq_vld;
    logic          ps_fq_pop;
    logic          ps_fq_flush;
    logic [IW-1:0] fq_ps_op;
    logic [AW-1:0] fq_ps_add;
    logic          fq_ps_vld;
    logic          fq_ps_stall;
    logic [CW-1:0] fq_ps_cnt;

    ps_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps_fq_req  (ps_fq_req),
        .ps_fq_add  (ps_fq_add),
        .pm_fq_op   (pm_fq_op),
        .pm_fq_vld  (pm_fq_vld),
        .ps_fq_pop  (ps_fq_pop),
        .ps_fq_flush(ps_fq_flush),
        .fq_ps_op   (fq_ps_op),
        .fq_ps_add  (fq_ps_add),
        .fq_ps_vld  (fq_ps_vld),
        .fq_ps_stall(fq_ps_stall),
        .fq_ps_cnt  (fq_ps_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] add;
        logic [IW-1:0] op;
    } entry_t;

    entry_t        exp_q[$];      // words the sequencer should see, in order
    bit            pend;          // a fetch is outstanding at PM
    logic [AW-1:0] pend_add;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, predict and check the
    // combinational outputs, then advance the model to the next rising edge.
    task automatic step(input bit req, input logic [AW-1:0] add, input bit pop,
                        input bit flush, input bit spur);
        int stored;
        bit ret, exp_stall, exp_vld, acc;
        @(negedge clk);
        ps_fq_req   = req;
        ps_fq_add   = add;
        ps_fq_pop   = pop;
        ps_fq_flush = flush;
        ret         = pend;
        pm_fq_vld   = pend | spur;
        pm_fq_op    = $urandom;
        stored      = exp_q.size();
        if (ret) exp_q.push_back('{pend_add, pm_fq_op});
        #2;
        exp_stall = !flush && ((stored + int'(pend)) >= DEPTH);
        exp_vld   = (stored > 0) || (BYP && ret && !flush && stored == 0);
        acc       = req && !exp_stall;
        check("stall", fq_ps_stall, exp_stall);
        check("cnt",   fq_ps_cnt, stored);
        check("vld",   fq_ps_vld, exp_vld);
        if (!exp_vld) begin
            check("nop_op",  fq_ps_op,  0);
            check("nop_add", fq_ps_add, 0);
        end
        if (flush) exp_q.delete();
        if (acc) begin
            pend     = 1'b1;
            pend_add = add;
        end else if (ret || flush) begin
            pend = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_vld",   fq_ps_vld,   0);
        check("rst_op",    fq_ps_op,    0);
        check("rst_add",   fq_ps_add,   0);
        check("rst_stall", fq_ps_stall, 0);
        check("rst_cnt",   fq_ps_cnt,   0);
        exp_q.delete();
        pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: the head must match the scoreboard front whenever it is valid.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && fq_ps_vld) begin
                if (exp_q.size() == 0) begin
                    check("head_unexpected", fq_ps_vld, 0);
                end else begin
                    check("head_add", fq_ps_add, exp_q[0].add);
                    check("head_op",  fq_ps_op,  exp_q[0].op);
                    if (ps_fq_pop && !ps_fq_flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ps_fq_req = 1'b0; ps_fq_add = '0; pm_fq_op = '0;
        pm_fq_vld = 1'b0; ps_fq_pop = 1'b0; ps_fq_flush = 1'b0;
        pend = 1'b0; pend_add = '0;
        apply_reset();

        // Fill without popping: the 5th request must be refused.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0010 + AW'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0014, 1'b0, 1'b0, 1'b0);
        check("fill_stall", fq_ps_stall, 1);
        step(1'b1, 16'h0014, 1'b0, 1'b0, 1'b0);
        check("fill_cnt", fq_ps_cnt, 4);
        check("fill_head", fq_ps_add, 16'h0010);

        // Reset while full: outputs clear without a clock edge.
        apply_reset();

        // 3 queued + 1 in flight, then a redirect that carries a new request.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0030 + AW'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0100, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("flush_cnt", fq_ps_cnt, 0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("flush_head_vld", fq_ps_vld, 1);
        check("flush_head", fq_ps_add, 16'h0100);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Pop on empty and spurious PM strobes are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("empty_cnt", fq_ps_cnt, 0);

        // Back-to-back requests with a pop every cycle: one per cycle, wraps.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h0020 + AW'(i), 1'b1, 1'b0, 1'b0);
            check("tput_cnt_le1", fq_ps_cnt <= 1, 1);
            check("tput_no_stall", fq_ps_stall, 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Request-to-valid latency with pop held high.
        step(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_k1_vld", fq_ps_vld, BYP);
        check("lat_k1_cnt", fq_ps_cnt, 0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_k2_vld", fq_ps_vld, !BYP);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 10) < 7, AW'($urandom), ($urandom % 10) < 6,
                 ($urandom % 20) == 0, !pend && (($urandom % 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
